// File: rtl/score_counter_if.sv
// Score counter bus: qualifier inputs, clear, and score/display outputs.
// Latency: none (wiring only).
// Backpressure: none; the inputs are level qualifiers sampled on every clock.
interface score_counter_if #(
    parameter int DIGITS = 2
);
    logic                  lwin;
    logic                  lno;
    logic                  Light;
    logic                  clear;
    logic [4*DIGITS-1:0]   count;
    logic [4*DIGITS-1:0]   best;
    logic [7*DIGITS-1:0]   hexDisplay;
    logic                  maxed;
    logic                  wrap;

    // The stimulus side drives the qualifiers and reads back the score.
    modport master (
        output lwin, lno, Light, clear,
        input  count, best, hexDisplay, maxed, wrap
    );

    // The counter samples the qualifiers and drives the score.
    modport slave (
        input  lwin, lno, Light, clear,
        output count, best, hexDisplay, maxed, wrap
    );
endinterface

// File: rtl/score_counter.sv
// BCD score counter: rising-edge event counting, round clear with best-score capture, 7-seg display.
// Latency: count, best and wrap update one cycle after the qualifying posedge; display and maxed follow count combinationally.
// Backpressure: none; at all nines the counter either holds or wraps to zero with a wrap pulse.
module score_counter #(
    parameter int DIGITS   = 2,
    parameter int SATURATE = 1,
    parameter int BLANK_LZ = 0
) (
    input  logic          Clock,
    input  logic          Reset,
    score_counter_if.slave bus
);
    localparam int W = 4 * DIGITS;

    logic [W-1:0]          count_q, count_d;
    logic [W-1:0]          best_q, best_d;
    logic                  ev_prev_q, ev_prev_d;
    logic                  wrap_q, wrap_d;

    logic                  ev;
    logic                  inc;
    logic [W-1:0]          count_inc;
    logic                  carry;
    logic                  all_nines;
    logic [7*DIGITS-1:0]   hex_dat;
    logic                  lead;
    logic [3:0]            dig;

    // Active-low gfedcba pattern for one BCD digit; non-BCD codes go blank.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // Qualified event and its rising edge; a held event counts only once.
    always_comb begin
        ev  = bus.Light & bus.lwin & ~bus.lno;
        inc = ev & ~ev_prev_q;
    end

    // Ripple BCD increment of the current score and the all-nines detect.
    always_comb begin
        count_inc = count_q;
        carry     = 1'b1;
        all_nines = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (count_q[4*i +: 4] != 4'd9) begin
                all_nines = 1'b0;
            end
            if (carry) begin
                if (count_q[4*i +: 4] == 4'd9) begin
                    count_inc[4*i +: 4] = 4'd0;
                end else begin
                    count_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                    carry               = 1'b0;
                end
            end
        end
    end

    // Next state: clear beats increment; best captures on clear only.
    // Packed BCD with valid digits orders the same as plain binary, so '>' is a BCD magnitude compare.
    always_comb begin
        count_d   = count_q;
        best_d    = best_q;
        wrap_d    = 1'b0;
        ev_prev_d = ev;
        if (bus.clear) begin
            count_d = '0;
            if (count_q > best_q) begin
                best_d = count_q;
            end
        end else if (inc) begin
            if (!all_nines) begin
                count_d = count_inc;
            end else if (SATURATE == 0) begin
                count_d = '0;
                wrap_d  = 1'b1;
            end
        end
    end

    // State registers with synchronous reset overriding clear and increment.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            count_q   <= '0;
            best_q    <= '0;
            ev_prev_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            best_q    <= best_d;
            ev_prev_q <= ev_prev_d;
            wrap_q    <= wrap_d;
        end
    end

    // Display decode, scanning from the top digit so leading zeros can blank; digit 0 always shows.
    always_comb begin
        hex_dat = '1;
        lead    = 1'b1;
        dig     = 4'd0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            dig = count_q[4*i +: 4];
            if ((BLANK_LZ != 0) && lead && (dig == 4'd0) && (i != 0)) begin
                hex_dat[7*i +: 7] = 7'b1111111;
            end else begin
                hex_dat[7*i +: 7] = seg7(dig);
                lead              = 1'b0;
            end
        end
    end

    assign bus.count      = count_q;
    assign bus.best       = best_q;
    assign bus.hexDisplay = hex_dat;
    assign bus.maxed      = all_nines;
    assign bus.wrap       = wrap_q;
endmodule

// File: tb/tb_score_counter.sv
// Bench for score_counter: two instances (saturating/unblanked and wrapping/blanked) share stimulus.
// Expected values are queued by the stimulus and compared by a negedge monitor.
// The wrap pulse count is accumulated by the monitor and compared per entry.
module tb_score_counter;
    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SB = 7'b1111111;

    logic Clock;
    logic Reset;
    logic lwin_s, lno_s, light_s, clear_s;

    int checks = 0;
    int errors = 0;
    int wraps0 = 0;
    int wraps1 = 0;

    typedef struct {
        string       name;
        logic [7:0]  c0, b0, c1, b1;
        logic [13:0] h0, h1;
        logic        m0, m1;
        int          w0, w1;
    } exp_t;

    exp_t exp_q[$];

    score_counter_if #(.DIGITS(2)) if0 ();
    score_counter_if #(.DIGITS(2)) if1 ();

    assign if0.lwin  = lwin_s;
    assign if0.lno   = lno_s;
    assign if0.Light = light_s;
    assign if0.clear = clear_s;
    assign if1.lwin  = lwin_s;
    assign if1.lno   = lno_s;
    assign if1.Light = light_s;
    assign if1.clear = clear_s;

    score_counter #(.DIGITS(2), .SATURATE(1), .BLANK_LZ(0)) dut0 (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (if0.slave)
    );

    score_counter #(.DIGITS(2), .SATURATE(0), .BLANK_LZ(1)) dut1 (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (if1.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: tally wrap pulses, then compare every queued expectation against the live outputs.
    always @(negedge Clock) begin
        exp_t e;
        if (if0.wrap === 1'b1) wraps0++;
        if (if1.wrap === 1'b1) wraps1++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({e.name, " count0"}, 32'(if0.count), 32'(e.c0));
            chk({e.name, " best0"},  32'(if0.best),  32'(e.b0));
            chk({e.name, " hex0"},   32'(if0.hexDisplay), 32'(e.h0));
            chk({e.name, " maxed0"}, 32'(if0.maxed), 32'(e.m0));
            chk({e.name, " wraps0"}, 32'(wraps0),    32'(e.w0));
            chk({e.name, " count1"}, 32'(if1.count), 32'(e.c1));
            chk({e.name, " best1"},  32'(if1.best),  32'(e.b1));
            chk({e.name, " hex1"},   32'(if1.hexDisplay), 32'(e.h1));
            chk({e.name, " maxed1"}, 32'(if1.maxed), 32'(e.m1));
            chk({e.name, " wraps1"}, 32'(wraps1),    32'(e.w1));
        end
    end

    task automatic push(input string nm,
                        input logic [7:0] c0, input logic [7:0] b0, input logic [13:0] h0,
                        input logic m0, input int w0,
                        input logic [7:0] c1, input logic [7:0] b1, input logic [13:0] h1,
                        input logic m1, input int w1);
        exp_t e;
        e.name = nm;
        e.c0 = c0; e.b0 = b0; e.h0 = h0; e.m0 = m0; e.w0 = w0;
        e.c1 = c1; e.b1 = b1; e.h1 = h1; e.m1 = m1; e.w1 = w1;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic set_ev(input logic v);
        light_s = v;
        lwin_s  = v;
        lno_s   = 1'b0;
    endtask

    task automatic pulses(input int n);
        for (int k = 0; k < n; k++) begin
            set_ev(1'b1);
            step();
            set_ev(1'b0);
            step();
        end
    endtask

    task automatic do_clear();
        clear_s = 1'b1;
        step();
        clear_s = 1'b0;
    endtask

    // Hard stop in case something stalls the stimulus.
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        Reset   = 1'b1;
        clear_s = 1'b0;
        set_ev(1'b0);
        step();
        step();
        Reset = 1'b0;
        push("reset", 8'h00, 8'h00, {S0, S0}, 1'b0, 0, 8'h00, 8'h00, {SB, S0}, 1'b0, 0);
        step();

        // Event held for five cycles counts once.
        set_ev(1'b1);
        repeat (5) step();
        set_ev(1'b0);
        step();
        push("hold5", 8'h01, 8'h00, {S0, S1}, 1'b0, 0, 8'h01, 8'h00, {SB, S1}, 1'b0, 0);

        // Veto: Light and lwin high with lno high must not count.
        light_s = 1'b1; lwin_s = 1'b1; lno_s = 1'b1;
        step();
        step();
        set_ev(1'b0);
        step();
        push("veto", 8'h01, 8'h00, {S0, S1}, 1'b0, 0, 8'h01, 8'h00, {SB, S1}, 1'b0, 0);

        // Reach 07, clear captures best.
        pulses(6);
        push("to07", 8'h07, 8'h00, {S0, S7}, 1'b0, 0, 8'h07, 8'h00, {SB, S7}, 1'b0, 0);
        do_clear();
        push("clr07", 8'h00, 8'h07, {S0, S0}, 1'b0, 0, 8'h00, 8'h07, {SB, S0}, 1'b0, 0);

        // Lower score at clear leaves best alone.
        pulses(3);
        do_clear();
        push("clr03", 8'h00, 8'h07, {S0, S0}, 1'b0, 0, 8'h00, 8'h07, {SB, S0}, 1'b0, 0);

        // Ten pulses: carry into digit 1.
        pulses(10);
        push("to10", 8'h10, 8'h07, {S1, S0}, 1'b0, 0, 8'h10, 8'h07, {S1, S0}, 1'b0, 0);

        // Clear together with a fresh event edge: no increment, and the held level does not count later.
        clear_s = 1'b1;
        set_ev(1'b1);
        step();
        clear_s = 1'b0;
        push("clr_inc", 8'h00, 8'h10, {S0, S0}, 1'b0, 0, 8'h00, 8'h10, {SB, S0}, 1'b0, 0);
        step();
        push("clr_hold", 8'h00, 8'h10, {S0, S0}, 1'b0, 0, 8'h00, 8'h10, {SB, S0}, 1'b0, 0);
        set_ev(1'b0);
        step();

        // 99 pulses to all nines, then one more: saturate vs wrap.
        pulses(99);
        push("to99", 8'h99, 8'h10, {S9, S9}, 1'b1, 0, 8'h99, 8'h10, {S9, S9}, 1'b1, 0);
        pulses(1);
        push("over99", 8'h99, 8'h10, {S9, S9}, 1'b1, 0, 8'h00, 8'h10, {SB, S0}, 1'b0, 1);

        // Clear: 99 beats best on the saturating unit, 00 does not on the wrapping one.
        do_clear();
        push("clr99", 8'h00, 8'h99, {S0, S0}, 1'b0, 0, 8'h00, 8'h10, {SB, S0}, 1'b0, 1);

        // Leading-zero blanking at 05.
        pulses(5);
        push("to05", 8'h05, 8'h99, {S0, S5}, 1'b0, 0, 8'h05, 8'h10, {SB, S5}, 1'b0, 1);

        // Reset while at 42 with an event edge pending.
        pulses(37);
        push("to42", 8'h42, 8'h99, {S4, S2}, 1'b0, 0, 8'h42, 8'h10, {S4, S2}, 1'b0, 1);
        Reset = 1'b1;
        set_ev(1'b1);
        step();
        push("rst42", 8'h00, 8'h00, {S0, S0}, 1'b0, 0, 8'h00, 8'h00, {SB, S0}, 1'b0, 1);

        // Event still high as reset releases counts on the first posedge.
        Reset = 1'b0;
        step();
        push("rst_ev", 8'h01, 8'h00, {S0, S1}, 1'b0, 0, 8'h01, 8'h00, {SB, S1}, 1'b0, 1);
        set_ev(1'b0);
        step();
        step();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/score_counter.md
SCORE_COUNTER -- requirements
Module: score_counter

Interface
REQ-001: Parameter DIGITS, default 2, number of BCD digits (legal 1..6).
REQ-002: Parameter SATURATE, default 1; 1 = hold at maximum, 0 = wrap to zero.
REQ-003: Parameter BLANK_LZ, default 0; 1 = blank leading-zero digits on the display.
REQ-004: Clock  input  1  sole clock; all state updates on posedge Clock.
REQ-005: Reset  input  1  synchronous, active-high reset.
REQ-006: lwin  input  1  win-condition qualifier.
REQ-007: lno  input  1  loss/veto qualifier; a high value blocks counting.
REQ-008: Light  input  1  light-position qualifier.
REQ-009: clear  input  1  synchronous round clear of the current score.
REQ-010: count  output  4*DIGITS  current score, BCD; digit i at [4i+3:4i].
REQ-011: best  output  4*DIGITS  highest score captured at a clear, BCD.
REQ-012: hexDisplay  output  7*DIGITS  active-low 7-segment patterns; digit i at [7i+6:7i].
REQ-013: maxed  output  1  level; high while count equals all nines.
REQ-014: wrap  output  1  one-cycle pulse on overflow to zero (SATURATE=0 only).

Function
REQ-015: Event ev = Light & lwin & ~lno, sampled each posedge Clock.
REQ-016: evPrev register stores the previous ev; inc = ev & ~evPrev, so each sustained ev high period counts exactly once.
REQ-017: When inc is high at posedge N, count is incremented by 1 (BCD) and visible after posedge N; latency 1 cycle.
REQ-018: BCD carry: digit 9 with carry-in becomes 0 and propagates a carry to digit i+1; no digit ever holds A-F.
REQ-019: At all nines with inc: SATURATE=1 leaves count unchanged and wrap stays 0; SATURATE=0 sets count to 0 and asserts wrap for exactly the following cycle.
REQ-020: maxed is combinational from count: 1 iff every digit equals 9.
REQ-021: clear has priority over inc: with clear high at a posedge, count becomes 0, the increment is discarded, and evPrev still updates to ev.
REQ-022: On a clear posedge, best <= count if count > best (BCD magnitude compare), else best unchanged.
REQ-023: best changes only on clear and Reset.
REQ-024: Segment map (gfedcba, active low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; blank=1111111.
REQ-025: hexDisplay is combinational from count; with BLANK_LZ=1, every digit above the most significant nonzero digit shows blank; digit 0 is always shown.
REQ-026: wrap is registered; all other outputs are combinational from registered state.

Reset
REQ-027: Reset at a posedge sets count=0, best=0, evPrev=0, wrap=0; it overrides clear and inc.
REQ-028: After reset, hexDisplay shows 1000000 in digit 0; other digits show 1000000 (BLANK_LZ=0) or 1111111 (BLANK_LZ=1); maxed=0.
REQ-029: Reset asserted mid-operation discards any pending increment. An ev already high when Reset falls counts on the first posedge after release, because evPrev=0.

Verification (DIGITS=2)
REQ-030: Reset, then ev held high for 5 cycles -> count=8'h01, hexDisplay[6:0]=1111001, with exactly one increment.
REQ-031: 10 separate ev pulses (one cycle high, one cycle low) -> count=8'h10; digit0 = 1000000, digit1 = 1111001.
REQ-032: SATURATE=1, 100 pulses -> count=8'h99, maxed=1, wrap never high; SATURATE=0, 100 pulses -> count=8'h00 with a single wrap pulse.
REQ-033: Score 8'h07, clear -> count=0, best=8'h07; then reach 8'h03, clear -> best stays 8'h07.
REQ-034: clear and an inc edge in the same cycle -> count=0 with no increment; the same ev level does not count again on the next cycle.
REQ-035: BLANK_LZ=1, count=8'h05 -> hexDisplay[13:7]=1111111, hexDisplay[6:0]=0010010; Reset during a count of 8'h42 -> count=0 and best=0 on the next cycle.
